// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: FS codes, Y mux encodings, MIPS opcode/funct constants,
// controller state type and the per-cycle control word shared by the controller files.
package datapath_ctrl_pkg;
    localparam logic [4:0] FS_ADD = 5'h02, FS_ADDU = 5'h03, FS_SUB = 5'h04, FS_SUBU = 5'h05;
    localparam logic [4:0] FS_AND = 5'h08, FS_OR = 5'h09, FS_XOR = 5'h0A, FS_NOR = 5'h0B;
    localparam logic [4:0] FS_SLL = 5'h0C, FS_SRL = 5'h0D, FS_MUL = 5'h1E, FS_DIV = 5'h1F;
    localparam logic [2:0] Y_ALU = 3'b000, Y_LO = 3'b001, Y_HI = 3'b010, Y_DY = 3'b011, Y_PC = 3'b100;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_MFHI = 6'h10, FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT = 6'h18, FN_DIV = 6'h1A, FN_ADD = 6'h20, FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26, FN_NOR = 6'h27;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB_HI, S_WB_LO} state_t;

    typedef struct packed {
        logic [4:0]  s_addr;
        logic [4:0]  t_addr;
        logic [4:0]  d_addr;
        logic        d_en;
        logic        t_sel;
        logic [31:0] dt;
        logic [31:0] dy;
        logic [2:0]  y_sel;
        logic        hilo_ld;
        logic [4:0]  fs;
    } ctrl_t;

    // {valid, fs} for the single-cycle R-type ALU functs
    function automatic logic [5:0] alu_fs(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return {1'b1, FS_ADD};
            FN_ADDU: return {1'b1, FS_ADDU};
            FN_SUB:  return {1'b1, FS_SUB};
            FN_SUBU: return {1'b1, FS_SUBU};
            FN_AND:  return {1'b1, FS_AND};
            FN_OR:   return {1'b1, FS_OR};
            FN_XOR:  return {1'b1, FS_XOR};
            FN_NOR:  return {1'b1, FS_NOR};
            FN_SLL:  return {1'b1, FS_SLL};
            FN_SRL:  return {1'b1, FS_SRL};
            default: return 6'd0;
        endcase
    endfunction
endpackage

// File: rtl/datapath_ctrl_decode.sv
// instr_decode: combinational map from the instruction register to the EXEC-cycle
// control word plus mul/div, illegal and flag-update indications.
module instr_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output ctrl_t       o_ctrl,
    output logic        o_muldiv,
    output logic        o_illegal,
    output logic        o_flag_upd
);
    logic [5:0]  w_op, w_fn, w_alu;
    logic [4:0]  w_rs, w_rt, w_rd, w_sh;
    logic [15:0] w_imm;
    logic        w_shift, w_wr;
    ctrl_t       w_c;

    assign w_op    = i_ir[31:26];
    assign w_rs    = i_ir[25:21];
    assign w_rt    = i_ir[20:16];
    assign w_rd    = i_ir[15:11];
    assign w_sh    = i_ir[10:6];
    assign w_fn    = i_ir[5:0];
    assign w_imm   = i_ir[15:0];
    assign w_alu   = alu_fs(w_fn);
    assign w_shift = (w_fn == FN_SLL) || (w_fn == FN_SRL);

    // the all-zero word is a NOP and leaves every control at zero
    always_comb begin
        w_c        = '0;
        w_wr       = 1'b0;
        o_muldiv   = 1'b0;
        o_illegal  = 1'b0;
        o_flag_upd = 1'b0;
        if (i_ir != 32'd0)
            case (w_op)
                OP_RTYPE:
                    if (w_alu[5] && !(w_shift && w_sh != 5'd1)) begin
                        w_c.s_addr = w_rs;
                        w_c.t_addr = w_rt;
                        w_c.d_addr = w_rd;
                        w_c.t_sel  = 1'b1;
                        w_c.y_sel  = Y_ALU;
                        w_c.fs     = w_alu[4:0];
                        w_wr       = 1'b1;
                        o_flag_upd = 1'b1;
                    end else if (w_fn == FN_MFHI || w_fn == FN_MFLO) begin
                        w_c.d_addr = w_rd;
                        w_c.y_sel  = (w_fn == FN_MFHI) ? Y_HI : Y_LO;
                        w_wr       = 1'b1;
                    end else if (w_fn == FN_MULT || w_fn == FN_DIV) begin
                        w_c.s_addr  = w_rs;
                        w_c.t_addr  = w_rt;
                        w_c.t_sel   = 1'b1;
                        w_c.hilo_ld = 1'b1;
                        w_c.fs      = (w_fn == FN_MULT) ? FS_MUL : FS_DIV;
                        o_muldiv    = 1'b1;
                    end else
                        o_illegal = 1'b1;
                OP_ADDI, OP_ANDI, OP_ORI: begin
                    w_c.s_addr = w_rs;
                    w_c.d_addr = w_rt;
                    w_c.fs     = (w_op == OP_ADDI) ? FS_ADD : (w_op == OP_ANDI) ? FS_AND : FS_OR;
                    w_c.dt     = (w_op == OP_ADDI) ? {{16{w_imm[15]}}, w_imm} : {16'd0, w_imm};
                    w_wr       = 1'b1;
                    o_flag_upd = 1'b1;
                end
                OP_LUI: begin
                    w_c.y_sel  = Y_DY;
                    w_c.dy     = {w_imm, 16'd0};
                    w_c.d_addr = w_rt;
                    w_wr       = 1'b1;
                end
                OP_JAL: begin
                    w_c.y_sel  = Y_PC;
                    w_c.d_addr = 5'd31;
                    w_wr       = 1'b1;
                end
                default: o_illegal = 1'b1;
            endcase
        w_c.d_en = w_wr && (w_c.d_addr != 5'd0);
    end

    assign o_ctrl = w_c;
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: valid/ready instruction sequencer driving integer_datapath controls;
// single-cycle ALU ops, three-cycle MULT/DIV with HI then LO writeback, latched ALU flags.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        C,
    input  logic        N,
    input  logic        V,
    input  logic        Z,
    output logic [4:0]  S_Addr,
    output logic [4:0]  T_Addr,
    output logic [4:0]  D_Addr,
    output logic        D_en,
    output logic        T_sel,
    output logic [31:0] DT,
    output logic [31:0] DY,
    output logic [2:0]  Y_sel,
    output logic        HILO_ld,
    output logic [4:0]  FS,
    output logic [3:0]  flags,
    output logic        err
);
    state_t      r_state, w_next;
    logic [31:0] r_ir;
    logic [3:0]  r_flags;
    logic [4:0]  w_rd;
    ctrl_t       w_dec, w_ctrl;
    logic        w_muldiv, w_illegal, w_flag_upd;

    instr_decode u_dec (
        .i_ir       (r_ir),
        .o_ctrl     (w_dec),
        .o_muldiv   (w_muldiv),
        .o_illegal  (w_illegal),
        .o_flag_upd (w_flag_upd)
    );

    assign w_rd = r_ir[15:11];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && instr_valid)
                r_ir <= instr;
            if (r_state == S_EXEC && w_flag_upd)
                r_flags <= {C, N, V, Z};
        end
    end

    // HI lands in rd+1 (wrapping), LO in rd; a wrap onto R0 suppresses the write
    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        case (r_state)
            S_IDLE: w_next = instr_valid ? S_EXEC : S_IDLE;
            S_EXEC: begin
                w_ctrl = w_dec;
                w_next = w_muldiv ? S_WB_HI : S_IDLE;
            end
            S_WB_HI: begin
                w_ctrl.y_sel  = Y_HI;
                w_ctrl.d_addr = w_rd + 5'd1;
                w_ctrl.d_en   = (w_rd != 5'd31);
                w_next        = S_WB_LO;
            end
            S_WB_LO: begin
                w_ctrl.y_sel  = Y_LO;
                w_ctrl.d_addr = w_rd;
                w_ctrl.d_en   = (w_rd != 5'd0);
                w_next        = S_IDLE;
            end
        endcase
    end

    assign instr_ready = (r_state == S_IDLE);
    assign err         = (r_state == S_EXEC) && w_illegal;
    assign S_Addr      = w_ctrl.s_addr;
    assign T_Addr      = w_ctrl.t_addr;
    assign D_Addr      = w_ctrl.d_addr;
    assign D_en        = w_ctrl.d_en;
    assign T_sel       = w_ctrl.t_sel;
    assign DT          = w_ctrl.dt;
    assign DY          = w_ctrl.dy;
    assign Y_sel       = w_ctrl.y_sel;
    assign HILO_ld     = w_ctrl.hilo_ld;
    assign FS          = w_ctrl.fs;
    assign flags       = r_flags;
endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Instruction-level control unit that drives every control input of `integer_datapath` (register addresses, write enable, T/Y mux selects, HI/LO load, ALU function select) from a MIPS-format instruction word. It accepts one instruction per valid/ready handshake, sequences single-cycle ALU ops and three-cycle MULT/DIV writebacks, and latches ALU status flags. It sits between instruction fetch and the datapath.

## Interface
Parameters: none. FS codes and opcode/funct constants come from the shared package.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  instruction word present
- `instr`  in  32  MIPS instruction word
- `instr_ready`  out  1  controller can accept (high only in IDLE)
- `C, N, V, Z`  in  1 each  datapath ALU flags
- `S_Addr, T_Addr, D_Addr`  out  5 each  register file addresses
- `D_en`  out  1  register file write enable
- `T_sel`  out  1  1 = RT, 0 = DT
- `DT`  out  32  immediate for the T mux
- `DY`  out  32  constant for Y mux input 011
- `Y_sel`  out  3  000 ALU_lo, 001 LO, 010 HI, 011 DY, 100 PC_in
- `HILO_ld`  out  1  load HI/LO
- `FS`  out  5  ALU function select
- `flags`  out  4  {C,N,V,Z} latched at end of last ALU EXEC
- `err`  out  1  one-cycle pulse on an illegal instruction

## Operation
- States: IDLE, EXEC, WB_HI, WB_LO.
- IDLE: `instr_ready`=1. On `instr_valid` the word goes into IR and the FSM moves to EXEC. All control outputs are 0.
- EXEC decodes IR as rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- R-type funct→FS: 20→02, 21→03, 22→04, 23→05, 24→08, 25→09, 26→0A, 27→0B, 00 SLL→0C, 02 SRL→0D. Drive S=rs, T=rt, D=rd, T_sel=1, Y_sel=000, D_en=1. Return to IDLE.
- SLL/SRL: shamt must equal 1. Any other shamt is illegal.
- MFHI (10) writes through Y_sel=010; MFLO (12) writes through Y_sel=001. Both have D=rd and take one cycle.
- MULT (18) uses FS=1E; DIV (1A) uses FS=1F. Drive S=rs, T=rt, T_sel=1, HILO_ld=1, D_en=0.
  - EXEC→WB_HI: Y_sel=010, D=(rd+1) mod 32, D_en=1.
  - WB_HI→WB_LO: Y_sel=001, D=rd, D_en=1.
  - WB_LO→IDLE.
- I-type, all with T_sel=0:
  - ADDI (08): FS=02, DT=sign-extended imm.
  - ANDI (0C): FS=08, DT=zero-extended imm.
  - ORI (0D): FS=09, DT=zero-extended imm.
  - These three use S=rs and D=rt.
  - LUI (0F): Y_sel=011, DY={imm,16'h0}, D=rt.
  - JAL (03): Y_sel=100, D=31.
- Instruction 0x00000000 is a NOP: one EXEC cycle, no write, no err.
- Destination 0 always forces D_en=0. This includes MULT/DIV with rd=31, where HI targets R0.
- Illegal opcode or funct: `err`=1 during EXEC, all writes suppressed, return to IDLE.
- `flags` captures {C,N,V,Z} at the clock edge leaving EXEC, only for R-type ALU ops and ADDI/ANDI/ORI. Otherwise it holds.

## Timing
- All control outputs are combinational from state+IR. `flags` and IR are registered.
- Latency per accepted instruction:
  - 2 cycles for single-cycle ops (accept edge, then EXEC).
  - 4 cycles for MULT/DIV.
- The register file write occurs at the rising edge that ends EXEC or WB_*.
- `instr_valid` outside IDLE is ignored. The source holds the word until ready.
- Reset values:
  - state=IDLE, IR=0, flags=0, err=0.
  - All datapath controls 0.
  - `instr_ready`=1.
- Reset asserted mid-operation: abort immediately to IDLE with D_en=0 and no further writebacks. HI/LO contents are not cleared.

## Structure
- Package `datapath_ctrl_pkg` holds:
  - FS code constants matching `integer_datapath`.
  - Y_sel encodings.
  - Opcode/funct constants.
  - State enum.
- Optional sub-module `instr_decode`: a combinational map from IR to a control word plus an is_muldiv/illegal/flag-update indication. The FSM wraps it.

## Test plan
- OR: 0x00640825 → EXEC shows FS=09, S=3, T=4, D=1, T_sel=1, Y_sel=000, D_en=1. Back in IDLE after 2 cycles.
- MULT: 0x01EE2818 → EXEC: FS=1E, HILO_ld=1, D_en=0. WB_HI: D=6, Y_sel=010. WB_LO: D=5, Y_sel=001. `instr_ready` low for 3 cycles.
- LUI 0x3C0CABCD → DY=0xABCD0000, Y_sel=011, D=12. ADDI 0x200AFFFB → DT=0xFFFFFFFB, T_sel=0, FS=02, D=10.
- Illegal funct 0x3F, SLL with shamt=2, and any write to rd=0 → D_en stays 0. The two illegal cases pulse `err` for one cycle.
- Drop `reset` during WB_HI of a DIV → outputs zero asynchronously, no WB_LO write, `instr_ready`=1 after release.
- ADD with datapath flags forced to 1011 → `flags`=1011 after EXEC. A following LUI leaves `flags` unchanged.
